// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the NoC link pipeline/monitor stage.
// Holds the framing state encoding, the flit layout and the credit-count
// width helper used by noc_link_channel and noc_link_pipe_monitor.
package noc_link_pkg;

    localparam int unsigned NOC_FLIT_WIDTH = 64;
    localparam int unsigned NOC_DEST_WIDTH = 6;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } link_state_e;

    // Flit layout as carried on the link (valid travels alongside).
    typedef struct packed {
        logic                      is_tail;
        logic [NOC_DEST_WIDTH-1:0] dest;
        logic [NOC_FLIT_WIDTH-1:0] data;
    } noc_flit_t;

    // Width able to hold every credit value from 0 up to the buffer depth.
    function automatic int unsigned credit_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_link_channel.sv
// One link channel: forward flit pipeline, reverse credit pipeline,
// credit occupancy monitor, packet framing FSM and sticky error flags.
// Optional statistics counters are built when NOC_LINK_STATS_EN is defined;
// otherwise flit_count/pkt_count are tied to zero.
module noc_link_channel
    import noc_link_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH        = NOC_FLIT_WIDTH,
    parameter int unsigned DEST_WIDTH        = NOC_DEST_WIDTH,
    parameter int unsigned NUM_PIPELINE      = 1,
    parameter int unsigned FLIT_BUFFER_DEPTH = 8,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                  clk_noc,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
    input  logic                  err_clear,
    output logic                  pkt_active,
    output logic                  err_overflow,
    output logic                  err_underflow,
    output logic                  err_dest,
    output logic [CNT_WIDTH-1:0]  flit_count,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    localparam int unsigned CW = credit_cnt_width(FLIT_BUFFER_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FLIT_BUFFER_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    // Payload fields are not reset; they only matter when send is high.
    typedef struct packed {
        logic [DEST_WIDTH-1:0] dest;
        logic [FLIT_WIDTH-1:0] data;
    } payload_t;

    logic credit_out_s;

    generate
        if (NUM_PIPELINE == 0) begin : g_pass
            assign send_out     = send_in;
            assign is_tail_out  = is_tail_in;
            assign dest_out     = dest_in;
            assign data_out     = data_in;
            assign credit_out_s = credit_in;
        end else begin : g_pipe
            logic [1:0] ctrl_pipe_r    [NUM_PIPELINE];
            payload_t   payload_pipe_r [NUM_PIPELINE];
            logic       credit_pipe_r  [NUM_PIPELINE];

            // Control stages ({send, is_tail} forward, credit reverse) with reset.
            always_ff @(posedge clk_noc or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(NUM_PIPELINE); i++) begin
                        ctrl_pipe_r[i]   <= 2'b00;
                        credit_pipe_r[i] <= 1'b0;
                    end
                end else begin
                    ctrl_pipe_r[0]   <= {send_in, is_tail_in};
                    credit_pipe_r[0] <= credit_in;
                    for (int i = 1; i < int'(NUM_PIPELINE); i++) begin
                        ctrl_pipe_r[i]   <= ctrl_pipe_r[i-1];
                        credit_pipe_r[i] <= credit_pipe_r[i-1];
                    end
                end
            end

            // Payload stages shift every cycle without reset or enable.
            always_ff @(posedge clk_noc) begin
                payload_pipe_r[0] <= '{dest: dest_in, data: data_in};
                for (int i = 1; i < int'(NUM_PIPELINE); i++) begin
                    payload_pipe_r[i] <= payload_pipe_r[i-1];
                end
            end

            assign send_out     = ctrl_pipe_r[NUM_PIPELINE-1][1];
            assign is_tail_out  = ctrl_pipe_r[NUM_PIPELINE-1][0];
            assign dest_out     = payload_pipe_r[NUM_PIPELINE-1].dest;
            assign data_out     = payload_pipe_r[NUM_PIPELINE-1].data;
            assign credit_out_s = credit_pipe_r[NUM_PIPELINE-1];
        end
    endgenerate

    assign credit_out = credit_out_s;

    // ---------------- credit monitor ----------------
    logic [CW-1:0] credit_cnt_r;
    logic [CW-1:0] credit_cnt_nxt_s;
    logic          ovf_evt_s;
    logic          unf_evt_s;

    // Next credit count and over/underflow events; simultaneous send and credit cancel.
    always_comb begin
        credit_cnt_nxt_s = credit_cnt_r;
        ovf_evt_s        = 1'b0;
        unf_evt_s        = 1'b0;
        case ({send_in, credit_out_s})
            2'b10: begin
                if (credit_cnt_r == CNT_ZERO) begin
                    ovf_evt_s = 1'b1;
                end else begin
                    credit_cnt_nxt_s = credit_cnt_r - CNT_ONE;
                end
            end
            2'b01: begin
                if (credit_cnt_r == DEPTH_CNT) begin
                    unf_evt_s = 1'b1;
                end else begin
                    credit_cnt_nxt_s = credit_cnt_r + CNT_ONE;
                end
            end
            default: begin
                credit_cnt_nxt_s = credit_cnt_r;
            end
        endcase
    end

    // Credit count register, starts full (downstream buffer empty).
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt_r <= DEPTH_CNT;
        end else begin
            credit_cnt_r <= credit_cnt_nxt_s;
        end
    end

    // ---------------- framing FSM ----------------
    link_state_e           state_r;
    link_state_e           state_nxt_s;
    logic [DEST_WIDTH-1:0] pkt_dest_r;
    logic [DEST_WIDTH-1:0] pkt_dest_nxt_s;
    logic                  dest_evt_s;

    // Framing next state: head opens a packet, tail closes it, dest must stay fixed.
    always_comb begin
        state_nxt_s    = state_r;
        pkt_dest_nxt_s = pkt_dest_r;
        dest_evt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (send_in && !is_tail_in) begin
                    state_nxt_s    = IN_PKT;
                    pkt_dest_nxt_s = dest_in;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IN_PKT: begin
                if (send_in) begin
                    dest_evt_s = (dest_in != pkt_dest_r);
                    if (is_tail_in) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = IN_PKT;
                    end
                end else begin
                    state_nxt_s = IN_PKT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Framing state and latched packet destination.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pkt_dest_r <= {DEST_WIDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            pkt_dest_r <= pkt_dest_nxt_s;
        end
    end

    assign pkt_active = (state_r == IN_PKT);

    // ---------------- sticky errors ----------------
    logic err_overflow_r;
    logic err_underflow_r;
    logic err_dest_r;

    // Sticky flags: a new event beats a concurrent clear.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow_r  <= 1'b0;
            err_underflow_r <= 1'b0;
            err_dest_r      <= 1'b0;
        end else begin
            err_overflow_r  <= ovf_evt_s  | (err_overflow_r  & ~err_clear);
            err_underflow_r <= unf_evt_s  | (err_underflow_r & ~err_clear);
            err_dest_r      <= dest_evt_s | (err_dest_r      & ~err_clear);
        end
    end

    assign err_overflow  = err_overflow_r;
    assign err_underflow = err_underflow_r;
    assign err_dest      = err_dest_r;

    // ---------------- statistics ----------------
`ifdef NOC_LINK_STATS_EN
    localparam logic [CNT_WIDTH-1:0] STAT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] STAT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] flit_cnt_r;
    logic [CNT_WIDTH-1:0] pkt_cnt_r;

    // Saturating flit/packet counters, cleared together with the error flags.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            flit_cnt_r <= {CNT_WIDTH{1'b0}};
            pkt_cnt_r  <= {CNT_WIDTH{1'b0}};
        end else if (err_clear) begin
            flit_cnt_r <= {CNT_WIDTH{1'b0}};
            pkt_cnt_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            if (send_in && (flit_cnt_r != STAT_MAX)) begin
                flit_cnt_r <= flit_cnt_r + STAT_ONE;
            end
            if (send_in && is_tail_in && (pkt_cnt_r != STAT_MAX)) begin
                pkt_cnt_r <= pkt_cnt_r + STAT_ONE;
            end
        end
    end

    assign flit_count = flit_cnt_r;
    assign pkt_count  = pkt_cnt_r;
`else
    assign flit_count = {CNT_WIDTH{1'b0}};
    assign pkt_count  = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: rtl/noc_link_pipe_monitor.sv
// Multi-channel credit-based router-to-router link stage: replicates
// noc_link_channel per link and shares err_clear across all channels.
// Optional statistics are enabled with the NOC_LINK_STATS_EN macro.
module noc_link_pipe_monitor
    import noc_link_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS      = 4,
    parameter int unsigned FLIT_WIDTH        = NOC_FLIT_WIDTH,
    parameter int unsigned DEST_WIDTH        = NOC_DEST_WIDTH,
    parameter int unsigned NUM_PIPELINE      = 1,
    parameter int unsigned FLIT_BUFFER_DEPTH = 8,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                                    clk_noc,
    input  logic                                    rst_n,
    input  logic [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0] data_in,
    input  logic [0:NUM_CHANNELS-1][DEST_WIDTH-1:0] dest_in,
    input  logic [0:NUM_CHANNELS-1]                 is_tail_in,
    input  logic [0:NUM_CHANNELS-1]                 send_in,
    output logic [0:NUM_CHANNELS-1]                 credit_out,
    output logic [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0] data_out,
    output logic [0:NUM_CHANNELS-1][DEST_WIDTH-1:0] dest_out,
    output logic [0:NUM_CHANNELS-1]                 is_tail_out,
    output logic [0:NUM_CHANNELS-1]                 send_out,
    input  logic [0:NUM_CHANNELS-1]                 credit_in,
    input  logic                                    err_clear,
    output logic [0:NUM_CHANNELS-1]                 pkt_active,
    output logic [0:NUM_CHANNELS-1]                 err_overflow,
    output logic [0:NUM_CHANNELS-1]                 err_underflow,
    output logic [0:NUM_CHANNELS-1]                 err_dest,
    output logic [0:NUM_CHANNELS-1][CNT_WIDTH-1:0]  flit_count,
    output logic [0:NUM_CHANNELS-1][CNT_WIDTH-1:0]  pkt_count
);

    generate
        for (genvar c = 0; c < int'(NUM_CHANNELS); c++) begin : g_ch
            noc_link_channel #(
                .FLIT_WIDTH        (FLIT_WIDTH),
                .DEST_WIDTH        (DEST_WIDTH),
                .NUM_PIPELINE      (NUM_PIPELINE),
                .FLIT_BUFFER_DEPTH (FLIT_BUFFER_DEPTH),
                .CNT_WIDTH         (CNT_WIDTH)
            ) u_ch (
                .clk_noc       (clk_noc),
                .rst_n         (rst_n),
                .data_in       (data_in[c]),
                .dest_in       (dest_in[c]),
                .is_tail_in    (is_tail_in[c]),
                .send_in       (send_in[c]),
                .credit_out    (credit_out[c]),
                .data_out      (data_out[c]),
                .dest_out      (dest_out[c]),
                .is_tail_out   (is_tail_out[c]),
                .send_out      (send_out[c]),
                .credit_in     (credit_in[c]),
                .err_clear     (err_clear),
                .pkt_active    (pkt_active[c]),
                .err_overflow  (err_overflow[c]),
                .err_underflow (err_underflow[c]),
                .err_dest      (err_dest[c]),
                .flit_count    (flit_count[c]),
                .pkt_count     (pkt_count[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_noc_link_pipe_monitor.sv
// Directed self-checking bench for noc_link_pipe_monitor with NUM_PIPELINE=2.
// Expected statistics follow the NOC_LINK_STATS_EN build setting.
module tb_noc_link_pipe_monitor;

    localparam int NCH = 4;
    localparam int FW  = 64;
    localparam int DW  = 6;
    localparam int NP  = 2;
    localparam int DEP = 8;
    localparam int CWD = 32;

    logic                    clk_noc;
    logic                    rst_n;
    logic [0:NCH-1][FW-1:0]  data_in;
    logic [0:NCH-1][DW-1:0]  dest_in;
    logic [0:NCH-1]          is_tail_in;
    logic [0:NCH-1]          send_in;
    logic [0:NCH-1]          credit_out;
    logic [0:NCH-1][FW-1:0]  data_out;
    logic [0:NCH-1][DW-1:0]  dest_out;
    logic [0:NCH-1]          is_tail_out;
    logic [0:NCH-1]          send_out;
    logic [0:NCH-1]          credit_in;
    logic                    err_clear;
    logic [0:NCH-1]          pkt_active;
    logic [0:NCH-1]          err_overflow;
    logic [0:NCH-1]          err_underflow;
    logic [0:NCH-1]          err_dest;
    logic [0:NCH-1][CWD-1:0] flit_count;
    logic [0:NCH-1][CWD-1:0] pkt_count;

    int n_cmp = 0;
    int n_bad = 0;
    int rx_cnt;

`ifdef NOC_LINK_STATS_EN
    localparam logic [63:0] EXP_FLITS = 64'd8;
    localparam logic [63:0] EXP_PKTS  = 64'd2;
`else
    localparam logic [63:0] EXP_FLITS = 64'd0;
    localparam logic [63:0] EXP_PKTS  = 64'd0;
`endif

    noc_link_pipe_monitor #(
        .NUM_CHANNELS      (NCH),
        .FLIT_WIDTH        (FW),
        .DEST_WIDTH        (DW),
        .NUM_PIPELINE      (NP),
        .FLIT_BUFFER_DEPTH (DEP),
        .CNT_WIDTH         (CWD)
    ) dut (
        .clk_noc       (clk_noc),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .dest_in       (dest_in),
        .is_tail_in    (is_tail_in),
        .send_in       (send_in),
        .credit_out    (credit_out),
        .data_out      (data_out),
        .dest_out      (dest_out),
        .is_tail_out   (is_tail_out),
        .send_out      (send_out),
        .credit_in     (credit_in),
        .err_clear     (err_clear),
        .pkt_active    (pkt_active),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_dest      (err_dest),
        .flit_count    (flit_count),
        .pkt_count     (pkt_count)
    );

    // Free-running 100 MHz NoC clock.
    initial begin
        clk_noc = 1'b0;
        forever #5 clk_noc = ~clk_noc;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples both sit 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic idle_inputs();
        send_in    = 4'b0000;
        is_tail_in = 4'b0000;
        credit_in  = 4'b0000;
        err_clear  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            data_in[c] = 64'd0;
            dest_in[c] = 6'd0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        // reset state
        check_eq("rst_send_out",  64'(send_out),      64'd0);
        check_eq("rst_credit",    64'(credit_out),    64'd0);
        check_eq("rst_pkt_act",   64'(pkt_active),    64'd0);
        check_eq("rst_errors",    64'({err_overflow, err_underflow, err_dest}), 64'd0);
        rst_n = 1'b1;
        tick();

        // ---- latency: flit on ch0, credit on ch1 ----
        send_in[0] = 1'b1; data_in[0] = 64'hA5; is_tail_in[0] = 1'b1; credit_in[1] = 1'b1;
        tick();
        idle_inputs();
        check_eq("lat_send_early",   64'(send_out[0]),   64'd0);
        check_eq("lat_credit_early", 64'(credit_out[1]), 64'd0);
        tick();
        check_eq("lat_send",    64'(send_out[0]),   64'd1);
        check_eq("lat_data",    data_out[0],        64'hA5);
        check_eq("lat_tail",    64'(is_tail_out[0]), 64'd1);
        check_eq("lat_credit",  64'(credit_out[1]), 64'd1);
        tick();
        check_eq("lat_send_once", 64'(send_out[0]), 64'd0);

        // ---- credit exhaustion on ch2 ----
        do_reset();
        rx_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k <= 9) begin
                send_in[2] = 1'b1; is_tail_in[2] = 1'b1; data_in[2] = 64'(k - 1);
            end else begin
                send_in[2] = 1'b0; is_tail_in[2] = 1'b0;
            end
            tick();
            if (send_out[2]) begin
                check_eq("ovf_data", data_out[2], 64'(rx_cnt));
                rx_cnt++;
            end
            if (k == 8) check_eq("ovf_before_9th", 64'(err_overflow[2]), 64'd0);
            if (k == 9) check_eq("ovf_on_9th",     64'(err_overflow[2]), 64'd1);
        end
        check_eq("ovf_all_flits", 64'(rx_cnt), 64'd9);
        check_eq("ovf_others",    64'(err_overflow), 64'h2);
        check_eq("ovf_no_unf",    64'(err_underflow), 64'd0);

        // ---- clear priority (ch2 count still 0) ----
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check_eq("clr_alone", 64'(err_overflow[2]), 64'd0);
        err_clear = 1'b1; send_in[2] = 1'b1; is_tail_in[2] = 1'b1;
        tick();
        idle_inputs();
        check_eq("clr_set_wins", 64'(err_overflow[2]), 64'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check_eq("clr_again", 64'(err_overflow[2]), 64'd0);

        // ---- underflow on ch3 and cancel on ch0 ----
        do_reset();
        credit_in[3] = 1'b1; credit_in[0] = 1'b1;
        tick();
        idle_inputs();
        tick();
        // credit_out[0] high this cycle: pair it with a send
        send_in[0] = 1'b1; is_tail_in[0] = 1'b1;
        check_eq("unf_not_yet", 64'(err_underflow[3]), 64'd0);
        tick();
        idle_inputs();
        check_eq("unf_set",        64'(err_underflow[3]), 64'd1);
        check_eq("cancel_no_unf",  64'(err_underflow[0]), 64'd0);
        check_eq("cancel_no_ovf",  64'(err_overflow[0]),  64'd0);
        // count should still be full, so one more credit underflows
        credit_in[0] = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        check_eq("cancel_count_full", 64'(err_underflow[0]), 64'd1);

        // ---- framing on ch1 ----
        do_reset();
        send_in[1] = 1'b1; dest_in[1] = 6'd5; is_tail_in[1] = 1'b0;
        tick();
        check_eq("frm_active_head", 64'(pkt_active[1]), 64'd1);
        dest_in[1] = 6'd5;
        tick();
        check_eq("frm_dest_ok",     64'(err_dest[1]),   64'd0);
        check_eq("frm_active_body", 64'(pkt_active[1]), 64'd1);
        dest_in[1] = 6'd7; is_tail_in[1] = 1'b1;
        tick();
        check_eq("frm_active_tail", 64'(pkt_active[1]), 64'd0);
        check_eq("frm_dest_err",    64'(err_dest[1]),   64'd1);
        dest_in[1] = 6'd3; is_tail_in[1] = 1'b1;
        tick();
        idle_inputs();
        check_eq("frm_single", 64'(pkt_active[1]), 64'd0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check_eq("frm_dest_clr", 64'(err_dest[1]), 64'd0);

        // ---- stats and reset mid-packet on ch0 ----
        do_reset();
        for (int f = 0; f < 8; f++) begin
            send_in[0] = 1'b1; dest_in[0] = 6'd9; data_in[0] = 64'(f);
            is_tail_in[0] = ((f % 4) == 3);
            tick();
        end
        idle_inputs();
        check_eq("stat_flits",  flit_count[0], EXP_FLITS);
        check_eq("stat_pkts",   pkt_count[0],  EXP_PKTS);
        check_eq("stat_no_ovf", 64'(err_overflow[0]), 64'd0);
        // third packet starts with no credits left
        send_in[0] = 1'b1; is_tail_in[0] = 1'b0; dest_in[0] = 6'd9; credit_in[0] = 1'b1;
        tick();
        tick();
        check_eq("mid_ovf",    64'(err_overflow[0]), 64'd1);
        check_eq("mid_active", 64'(pkt_active[0]),   64'd1);
        check_eq("mid_credit", 64'(credit_out[0]),   64'd1);
        check_eq("mid_send",   64'(send_out[0]),     64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_send",   64'(send_out),    64'd0);
        check_eq("arst_tail",   64'(is_tail_out), 64'd0);
        check_eq("arst_credit", 64'(credit_out),  64'd0);
        check_eq("arst_active", 64'(pkt_active),  64'd0);
        check_eq("arst_errors", 64'({err_overflow, err_underflow, err_dest}), 64'd0);
        check_eq("arst_flits",  flit_count[0], 64'd0);
        check_eq("arst_pkts",   pkt_count[0],  64'd0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        // credit count back at full depth: 8 sends fit, the 9th overflows
        for (int f = 0; f < 9; f++) begin
            send_in[0] = 1'b1; is_tail_in[0] = 1'b1;
            tick();
            if (f == 7) check_eq("arst_cnt_full", 64'(err_overflow[0]), 64'd0);
        end
        idle_inputs();
        check_eq("arst_cnt_ovf", 64'(err_overflow[0]), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/noc_link_pipe_monitor.md
Name: noc_link_pipe_monitor

Overview:
- Multi-channel, credit-based, router-to-router link stage for the NoC fabric.
- Sits between a router output port group and the neighbouring router input ports.
- Per channel:
  - pipelines the forward flit path and the reverse credit path by NUM_PIPELINE cycles;
  - tracks credit occupancy and packet framing;
  - raises sticky protocol-error flags.
- Replaces plain passthrough wiring between routers and adds timing-closure registers plus link-level checking.

Parameters:
- NUM_CHANNELS, 4, number of independent links (e.g. N/S/E/W).
- FLIT_WIDTH, 64, flit data width.
- DEST_WIDTH, 6, destination field width.
- NUM_PIPELINE, 1, register stages per direction; 0 = combinational passthrough.
- FLIT_BUFFER_DEPTH, 8, downstream input buffer depth; initial credit count.
- CNT_WIDTH, 32, width of the optional statistics counters.

Ports:
- clk_noc  input  1  NoC clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0]  flit data from upstream.
- dest_in  input  [0:NUM_CHANNELS-1][DEST_WIDTH-1:0]  flit destination.
- is_tail_in  input  [0:NUM_CHANNELS-1]  last flit of packet.
- send_in  input  [0:NUM_CHANNELS-1]  flit valid.
- credit_out  output  [0:NUM_CHANNELS-1]  credit returned upstream.
- data_out  output  [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0]  flit data downstream.
- dest_out  output  [0:NUM_CHANNELS-1][DEST_WIDTH-1:0]  flit destination downstream.
- is_tail_out  output  [0:NUM_CHANNELS-1]  tail flag downstream.
- send_out  output  [0:NUM_CHANNELS-1]  flit valid downstream.
- credit_in  input  [0:NUM_CHANNELS-1]  credit from downstream.
- err_clear  input  1  synchronous clear of all sticky error flags.
- pkt_active  output  [0:NUM_CHANNELS-1]  channel is mid-packet.
- err_overflow  output  [0:NUM_CHANNELS-1]  sticky: flit sent with zero credits.
- err_underflow  output  [0:NUM_CHANNELS-1]  sticky: credit returned above FLIT_BUFFER_DEPTH.
- err_dest  output  [0:NUM_CHANNELS-1]  sticky: dest changed mid-packet.
- flit_count  output  [0:NUM_CHANNELS-1][CNT_WIDTH-1:0]  flits seen (optional feature).
- pkt_count  output  [0:NUM_CHANNELS-1][CNT_WIDTH-1:0]  tails seen (optional feature).

Behaviour:
- Clocking and reset:
  - Single clock domain, clk_noc.
  - rst_n is asynchronous active-low and clears all control state immediately.
- Forward path:
  - Per channel, a NUM_PIPELINE-deep shift register of {send, is_tail, dest, data}; latency is exactly NUM_PIPELINE cycles.
  - send and is_tail stages reset to 0; data/dest stages are not reset.
  - Data, dest and is_tail propagate every cycle, with no enable.
  - No flit is dropped or duplicated.
- Reverse path:
  - credit_in is shifted through NUM_PIPELINE stages to credit_out; stages reset to 0.
  - NUM_PIPELINE=0 wires everything through, including the reset values.
- Credit monitor (per channel, at the link input):
  - Counter width is $clog2(FLIT_BUFFER_DEPTH+1); reset value is FLIT_BUFFER_DEPTH.
  - send_in decrements; credit_out increments; both in the same cycle leave it unchanged.
  - send_in while the count is 0 (and no simultaneous credit_out): set err_overflow, count holds at 0, flit is still forwarded.
  - credit_out while the count is FLIT_BUFFER_DEPTH (and no simultaneous send_in): set err_underflow, count holds.
- Framing FSM (per channel):
  - States are IDLE and IN_PKT; reset state is IDLE.
  - IDLE: send_in & ~is_tail_in goes to IN_PKT and latches dest_in. Single-flit packets (tail in IDLE) stay in IDLE.
  - IN_PKT: send_in with dest_in not equal to the latched dest sets err_dest. send_in & is_tail_in goes to IDLE.
  - pkt_active = (state == IN_PKT).
- Sticky errors:
  - All reset to 0.
  - err_clear zeroes them next cycle.
  - A set event in the same cycle as err_clear wins: the flag is 1.
- Output reset values: all outputs are 0 under reset, except data_out/dest_out, which are don't-care when NUM_PIPELINE>0.

Optional Feature:
- Macro: NOC_LINK_STATS_EN.
- Defined: per-channel flit_count increments on send_in, pkt_count increments on send_in & is_tail_in.
  - Both reset to 0 and saturate at all-ones.
  - err_clear also clears both counters.
- Undefined: both ports remain and are tied to 0; no counter registers are generated.

Decomposition:
- Package noc_link_pkg holds:
  - the framing state enum (IDLE, IN_PKT);
  - a packed flit struct typedef {is_tail, dest, data}, parametrised through localparam widths;
  - the credit-count width helper function.
- One sub-module, noc_link_channel, implements a single channel (pipelines, credit counter, FSM, stats).
- The top level instantiates NUM_CHANNELS copies in a generate loop and shares err_clear.

Test Plan:
- Latency: NUM_PIPELINE=2; send_in[0]=1, data 0xA5 for one cycle -> send_out[0]=1 with data_out 0xA5 exactly 2 cycles later. credit_in[1] pulse -> credit_out[1] 2 cycles later.
- Credit exhaustion: FLIT_BUFFER_DEPTH=8, no credits returned; send 9 flits on channel 2 -> err_overflow[2] rises on the 9th, all 9 flits appear on send_out, other channels' flags stay 0.
- Credit underflow: after reset, one extra credit_in[3] pulse -> err_underflow[3]=1 NUM_PIPELINE+1 cycles later. Simultaneous send_in/credit_out keeps the count at 8 with no error.
- Framing: 3-flit packet on channel 1 with dest 5, 5, 7 -> pkt_active[1] high after flit 1 and low after the tail; err_dest[1]=1. A single-tail flit never asserts pkt_active.
- Clear priority: overflow event in the same cycle as err_clear -> err_overflow stays 1. err_clear alone -> 0 next cycle.
- Reset mid-packet / stats: with NOC_LINK_STATS_EN, send 2 packets of 4 flits -> flit_count=8, pkt_count=2. Assert rst_n=0 mid-packet -> send_out, credit_out, pkt_active, errors and counters are all 0 immediately; the credit count returns to 8.
